// File: rtl/sap1_core_if.sv
// Memory bus between the SAP-1 core (master) and the 16x8 program/data memory (slave).
interface sap1_core_if;
  logic [3:0] mem_addr;
  logic       mem_ce_n;
  logic [7:0] bus_in;

  modport master (output mem_addr, output mem_ce_n, input bus_in);
  modport slave  (input mem_addr, input mem_ce_n, output bus_in);
endinterface

// File: rtl/sap1_core.sv
// SAP-1 core: PC, MAR, IR, A, B, adder/subtractor, output register and six-state ring controller.
// Optional carry/zero flags are enabled by defining SAP1_FLAGS_EN; otherwise both flags read 0.
module sap1_core (
  input  logic        clk,
  input  logic        clr_n,
  sap1_core_if.master mem,
  output logic [7:0]  out_reg,
  output logic        halted,
  output logic        carry,
  output logic        zero
);

  typedef enum logic [2:0] {T1, T2, T3, T4, T5, T6} state_t;

  localparam logic [3:0] OP_LDA = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_OUT = 4'b1110;
  localparam logic [3:0] OP_HLT = 4'b1111;

  state_t     state;
  logic [3:0] pc;
  logic [3:0] mar;
  logic [7:0] ir;
  logic [7:0] a;
  logic [7:0] b;
  logic [3:0] opcode;
  logic       is_mem_op;
  logic       is_sub;
  logic [7:0] alu_result;

  assign opcode    = ir[7:4];
  assign is_mem_op = (opcode == OP_LDA) || (opcode == OP_ADD) || (opcode == OP_SUB);
  assign is_sub    = (opcode == OP_SUB);

  assign mem.mem_addr = mar;
  assign mem.mem_ce_n = !((state == T3) || ((state == T5) && is_mem_op));

`ifdef SAP1_FLAGS_EN
  // SUB is A + ~B + 1 so bit 8 reads as "no borrow".
  logic [8:0] alu_full;
  assign alu_full   = is_sub ? ({1'b0, a} + {1'b0, ~b} + 9'd1) : ({1'b0, a} + {1'b0, b});
  assign alu_result = alu_full[7:0];
`else
  assign alu_result = is_sub ? (a - b) : (a + b);
  assign carry      = 1'b0;
  assign zero       = 1'b0;
`endif

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state   <= T1;
      pc      <= 4'h0;
      mar     <= 4'h0;
      ir      <= 8'h00;
      a       <= 8'h00;
      b       <= 8'h00;
      out_reg <= 8'h00;
      halted  <= 1'b0;
`ifdef SAP1_FLAGS_EN
      carry   <= 1'b0;
      zero    <= 1'b0;
`endif
    end else begin
      case (state)
        T1: begin
          mar   <= pc;
          state <= T2;
        end
        T2: begin
          pc    <= pc + 4'h1;
          state <= T3;
        end
        T3: begin
          ir    <= mem.bus_in;
          state <= T4;
        end
        T4: begin
          state <= T5;
          if (is_mem_op) begin
            mar <= ir[3:0];
          end else if (opcode == OP_OUT) begin
            out_reg <= a;
          end else if (opcode == OP_HLT) begin
            // Parking in T4 with HLT still in IR repeats this branch forever.
            halted <= 1'b1;
            state  <= T4;
          end
        end
        T5: begin
          if (opcode == OP_LDA) begin
            a <= mem.bus_in;
          end else if (is_mem_op) begin
            b <= mem.bus_in;
          end
          state <= T6;
        end
        T6: begin
          if ((opcode == OP_ADD) || is_sub) begin
            a <= alu_result;
`ifdef SAP1_FLAGS_EN
            carry <= alu_full[8];
            zero  <= (alu_result == 8'h00);
`endif
          end
          state <= T1;
        end
        default: state <= T1;
      endcase
    end
  end

endmodule

// File: tb/tb_sap1_core.sv
// Directed testbench for sap1_core: runs small programs from a combinational 16x8 memory model.
module tb_sap1_core;

  logic       clk = 1'b0;
  logic       clr_n = 1'b1;
  logic [7:0] out_reg;
  logic       halted;
  logic       carry;
  logic       zero;
  logic [7:0] mem [16];
  int         checks = 0;
  int         errors = 0;

`ifdef SAP1_FLAGS_EN
  localparam bit FLAGS_ON = 1'b1;
`else
  localparam bit FLAGS_ON = 1'b0;
`endif

  always #5 clk = ~clk;

  sap1_core_if mem_bus ();

  // Bus floats to X when not enabled so an out-of-window sample corrupts state visibly.
  assign mem_bus.bus_in = mem_bus.mem_ce_n ? 8'hxx : mem[mem_bus.mem_addr];

  sap1_core dut (
    .clk     (clk),
    .clr_n   (clr_n),
    .mem     (mem_bus.master),
    .out_reg (out_reg),
    .halted  (halted),
    .carry   (carry),
    .zero    (zero)
  );

  task tick();
    @(posedge clk);
    #1;
  endtask

  task start_run();
    @(negedge clk);
    clr_n = 1'b0;
    @(negedge clk);
    clr_n = 1'b1;
  endtask

  task load_basic();
    for (int i = 0; i < 16; i++) mem[i] = 8'h30;
    mem[0]  = 8'h09;
    mem[1]  = 8'h1A;
    mem[2]  = 8'h2B;
    mem[3]  = 8'hE0;
    mem[4]  = 8'hF0;
    mem[9]  = 8'h10;
    mem[10] = 8'h14;
    mem[11] = 8'h18;
  endtask

  task test_reset();
    @(posedge clk);
    #2;
    clr_n = 1'b0;
    #1;
    checks++;
    if ({mem_bus.mem_addr, mem_bus.mem_ce_n, out_reg, halted, carry, zero} !== {4'h0, 1'b1, 8'h00, 3'b000}) begin
      errors++;
      $display("[TB] FAIL reset_async: addr/ce_n/out/halted/carry/zero got %h %b %h %b %b %b required 0 1 00 0 0 0",
               mem_bus.mem_addr, mem_bus.mem_ce_n, out_reg, halted, carry, zero);
    end
    tick();
    checks++;
    if ({mem_bus.mem_addr, mem_bus.mem_ce_n, out_reg, halted} !== {4'h0, 1'b1, 8'h00, 1'b0}) begin
      errors++;
      $display("[TB] FAIL reset_held: addr/ce_n/out/halted got %h %b %h %b required 0 1 00 0",
               mem_bus.mem_addr, mem_bus.mem_ce_n, out_reg, halted);
    end
  endtask

  task test_basic_program();
    load_basic();
    start_run();
    for (int e = 1; e <= 28; e++) begin
      tick();
      if (e == 21 || e == 22) begin
        checks++;
        if (out_reg !== ((e == 22) ? 8'h0C : 8'h00)) begin
          errors++;
          $display("[TB] FAIL basic_out_edge%0d: out_reg got %h required %h", e, out_reg,
                   (e == 22) ? 8'h0C : 8'h00);
        end
      end
      if (e == 27 || e == 28) begin
        checks++;
        if (halted !== (e == 28)) begin
          errors++;
          $display("[TB] FAIL basic_halt_edge%0d: halted got %b required %b", e, halted, (e == 28));
        end
      end
    end
  endtask

  task test_halt_persistence();
    for (int c = 0; c < 50; c++) begin
      tick();
      checks++;
      if ({out_reg, mem_bus.mem_addr, mem_bus.mem_ce_n, halted} !== {8'h0C, 4'h4, 1'b1, 1'b1}) begin
        errors++;
        $display("[TB] FAIL halt_hold_c%0d: out/addr/ce_n/halted got %h %h %b %b required 0c 4 1 1",
                 c, out_reg, mem_bus.mem_addr, mem_bus.mem_ce_n, halted);
      end
    end
  endtask

  task test_bus_protocol();
    logic [3:0] op;
    logic       memop;
    logic       exp_ce;
    load_basic();
    start_run();
    checks++;
    if ({mem_bus.mem_ce_n, mem_bus.mem_addr} !== {1'b1, 4'h0}) begin
      errors++;
      $display("[TB] FAIL bus_idle: ce_n/addr got %b %h required 1 0", mem_bus.mem_ce_n, mem_bus.mem_addr);
    end
    for (int k = 0; k <= 4; k++) begin
      op    = mem[k][7:4];
      memop = (op == 4'h0) || (op == 4'h1) || (op == 4'h2);
      for (int t = 1; t <= ((k == 4) ? 4 : 6); t++) begin
        tick();
        exp_ce = !((t == 2) || ((t == 4) && memop));
        checks++;
        if (mem_bus.mem_ce_n !== exp_ce) begin
          errors++;
          $display("[TB] FAIL bus_ce_i%0d_e%0d: mem_ce_n got %b required %b", k, t, mem_bus.mem_ce_n, exp_ce);
        end
        if (t == 2 || (t == 4 && memop)) begin
          checks++;
          if (mem_bus.mem_addr !== ((t == 2) ? 4'(k) : mem[k][3:0])) begin
            errors++;
            $display("[TB] FAIL bus_addr_i%0d_e%0d: mem_addr got %h required %h", k, t, mem_bus.mem_addr,
                     (t == 2) ? 4'(k) : mem[k][3:0]);
          end
        end
      end
    end
  endtask

  task test_flags();
    for (int i = 0; i < 16; i++) mem[i] = 8'h30;
    mem[0]  = 8'h08;
    mem[1]  = 8'h19;
    mem[2]  = 8'hE0;
    mem[3]  = 8'h2A;
    mem[4]  = 8'hE0;
    mem[5]  = 8'hF0;
    mem[8]  = 8'hF0;
    mem[9]  = 8'h20;
    mem[10] = 8'h10;
    start_run();
    for (int e = 1; e <= 34; e++) begin
      tick();
      if (e == 11 || e == 12 || e == 23 || e == 24) begin
        checks++;
        if ({carry, zero} !== {FLAGS_ON && (e != 11), FLAGS_ON && (e == 24)}) begin
          errors++;
          $display("[TB] FAIL flags_edge%0d: carry/zero got %b %b required %b %b", e, carry, zero,
                   FLAGS_ON && (e != 11), FLAGS_ON && (e == 24));
        end
      end
      if (e == 16 || e == 28) begin
        checks++;
        if (out_reg !== ((e == 16) ? 8'h10 : 8'h00)) begin
          errors++;
          $display("[TB] FAIL flags_out_edge%0d: out_reg got %h required %h", e, out_reg,
                   (e == 16) ? 8'h10 : 8'h00);
        end
      end
    end
    checks++;
    if (halted !== 1'b1) begin
      errors++;
      $display("[TB] FAIL flags_halt: halted got %b required 1", halted);
    end
  endtask

  task test_pc_wrap();
    for (int i = 0; i < 16; i++) mem[i] = 8'h30;
    start_run();
    for (int k = 0; k <= 16; k++) begin
      for (int t = 1; t <= 6; t++) begin
        tick();
        if (t == 2) begin
          checks++;
          if ({mem_bus.mem_addr, mem_bus.mem_ce_n} !== {k[3:0], 1'b0}) begin
            errors++;
            $display("[TB] FAIL wrap_fetch_i%0d: addr/ce_n got %h %b required %h 0", k,
                     mem_bus.mem_addr, mem_bus.mem_ce_n, k[3:0]);
          end
        end
      end
    end
    checks++;
    if (halted !== 1'b0) begin
      errors++;
      $display("[TB] FAIL wrap_no_halt: halted got %b required 0", halted);
    end
  endtask

  task test_reset_mid();
    load_basic();
    start_run();
    repeat (10) tick();
    checks++;
    if ({mem_bus.mem_ce_n, mem_bus.mem_addr} !== {1'b0, 4'hA}) begin
      errors++;
      $display("[TB] FAIL mid_add_t5: ce_n/addr got %b %h required 0 a", mem_bus.mem_ce_n, mem_bus.mem_addr);
    end
    #2;
    clr_n = 1'b0;
    #1;
    checks++;
    if ({mem_bus.mem_addr, mem_bus.mem_ce_n, out_reg, halted, carry, zero} !== {4'h0, 1'b1, 8'h00, 3'b000}) begin
      errors++;
      $display("[TB] FAIL mid_reset: addr/ce_n/out/halted/carry/zero got %h %b %h %b %b %b required 0 1 00 0 0 0",
               mem_bus.mem_addr, mem_bus.mem_ce_n, out_reg, halted, carry, zero);
    end
    @(negedge clk);
    clr_n = 1'b1;
    for (int e = 1; e <= 22; e++) begin
      tick();
      if (e == 2 || e == 4) begin
        checks++;
        if ({mem_bus.mem_ce_n, mem_bus.mem_addr} !== {1'b0, (e == 2) ? 4'h0 : 4'h9}) begin
          errors++;
          $display("[TB] FAIL mid_restart_e%0d: ce_n/addr got %b %h required 0 %h", e,
                   mem_bus.mem_ce_n, mem_bus.mem_addr, (e == 2) ? 4'h0 : 4'h9);
        end
      end
    end
    checks++;
    if (out_reg !== 8'h0C) begin
      errors++;
      $display("[TB] FAIL mid_rerun_out: out_reg got %h required 0c", out_reg);
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 8'h30;
    $display("[TB] starting sap1_core tests");
    test_reset();
    test_basic_program();
    test_halt_persistence();
    test_reset();
    test_bus_protocol();
    test_flags();
    test_pc_wrap();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
